rx_tx_enable_seq: RTL and testbench
===================================

// Module: rx_tx_enable_seq
//
// PURPOSE
//   Multi-channel staggered enable sequencer. This is the parametrised successor to the single-bit registered enable.
//   After reset it waits a startup delay, then raises NUM_CH enables one at a time, STAGGER_CYCLES apart.
//   When run drops, it lowers them in reverse order. This limits inrush and link-training collisions.
//   It sits between the board reset/control register and the per-lane RX/TX enable inputs.
//
// PARAMETERS
//   NUM_CH          4    number of enable outputs (1..32)
//   STARTUP_CYCLES  16   clk cycles from first run request after reset to enable[0] (>=1)
//   STAGGER_CYCLES  8    clk cycles between successive channel edges (>=1)
//   CNT_W           16   delay counter width; STARTUP_CYCLES and STAGGER_CYCLES must be < 2**CNT_W
//
// PORTS
//   clk       in   1                     system clock; all logic on rising edge
//   resetn    in   1                     asynchronous, active-low reset
//   run       in   1                     1 = bring channels up, 0 = bring channels down
//   enable    out  NUM_CH                per-channel enable, thermometer coded from bit 0
//   up_count  out  $clog2(NUM_CH+1)      number of enabled channels (popcount of enable)
//   all_up    out  1                     enable == all ones
//   all_down  out  1                     enable == 0
//   busy      out  1                     state is STARTUP, RAMP_UP or RAMP_DOWN
//
// BEHAVIOUR
//   - One clock. Reset is asynchronous and active-low: resetn=0 forces all state immediately, without waiting for clk.
//   - Reset values:
//       enable=0, up_count=0, all_down=1, all_up=0, busy=0
//       state=IDLE, warm=0, counter=0
//   - Deassertion of resetn is synchronous to clk; an upstream synchroniser guarantees this.
//   - All outputs are registered. No combinational path from run to any output.
//   - Invariant: enable is always of the form 0..01..1. It changes by at most one bit per edge.
//   - FSM states: IDLE, STARTUP, RAMP_UP, UP, RAMP_DOWN.
//   - IDLE, run=1 sampled at edge E:
//       warm=0: go to STARTUP. enable[0] rises at E+STARTUP_CYCLES. warm is then set.
//       warm=1: go to RAMP_UP. enable[0] rises at E+STAGGER_CYCLES.
//   - RAMP_UP: enable[k] rises STAGGER_CYCLES edges after enable[k-1].
//       When enable[NUM_CH-1] rises, the state becomes UP on the same edge.
//   - UP, run=0 sampled at edge F:
//       The highest set bit clears at F+1.
//       Each further bit clears STAGGER_CYCLES edges after the previous one, in RAMP_DOWN.
//       When bit 0 clears, the state becomes IDLE on the same edge.
//   - STARTUP, run=0: return to IDLE, enable stays 0, warm stays 0.
//       A later run=1 restarts the full startup delay.
//   - RAMP_UP, run=0 sampled at edge G: go to RAMP_DOWN. The highest set bit clears at G+1.
//   - RAMP_DOWN, run=1 sampled at edge H: go to RAMP_UP.
//       The next channel rises at H+STAGGER_CYCLES. Startup is not repeated.
//   - A change of run always restarts the delay counter. Partial stagger intervals are discarded.
//   - NUM_CH=1: STARTUP/IDLE go straight to UP when enable[0] rises. RAMP_DOWN ends in one step.
//   - up_count, all_up, all_down and busy are updated on the same edge as enable. They always match enable.
//   - resetn asserted mid-ramp: all enables drop asynchronously and warm clears.
//       The next sequence after reset includes the full startup delay.
//
// TESTING  (defaults: NUM_CH=4, STARTUP=16, STAGGER=8)
//   1. Release reset, run=1 at edge 0
//        -> enable = 0001@16, 0011@24, 0111@32, 1111@40
//        -> all_up=1 and busy=0 from 40
//   2. From UP, run=0 sampled at edge 100
//        -> enable = 0111@101, 0011@109, 0001@117, 0000@125
//        -> all_down=1 at 125
//   3. Warm restart: run=1 sampled at edge 200 in IDLE
//        -> enable = 0001@208 (no startup), 1111@232
//   4. Mid-ramp reversal: run=0 sampled at edge 30 of test 1
//        -> enable = 0001@31, 0000@39
//        -> run=1 sampled at edge 50 gives 0001@58
//   5. resetn=0 asynchronously at edge 28+3ns
//        -> enable=0 immediately; all outputs at reset values
//        -> after release, next enable[0] rises STARTUP_CYCLES after run is sampled
//   6. NUM_CH=1, STARTUP=1, STAGGER=1: run pulse high 1 cycle
//        -> enable toggles cleanly
//        -> every cycle: thermometer invariant holds and up_count==popcount(enable)

Source files
------------

// File: rtl/rx_tx_enable_seq.sv
// rx_tx_enable_seq
//   Staggered multi-channel enable sequencer. After the first run request
//   following reset it waits STARTUP_CYCLES, then raises NUM_CH enables one
//   at a time, STAGGER_CYCLES apart. When run drops, it lowers them in
//   reverse order. The first lowering step happens on the edge after run is
//   seen low.
//
// Ports
//   clk       system clock, rising edge
//   resetn    asynchronous active-low reset
//   run       1 = bring channels up, 0 = bring channels down
//   enable    per-channel enable, thermometer coded from bit 0
//   up_count  number of enabled channels
//   all_up    enable is all ones
//   all_down  enable is zero
//   busy      sequencer is in STARTUP, RAMP_UP or RAMP_DOWN
module rx_tx_enable_seq #(
  parameter int NUM_CH         = 4,
  parameter int STARTUP_CYCLES = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         run,
  output logic [NUM_CH-1:0]            enable,
  output logic [$clog2(NUM_CH+1)-1:0]  up_count,
  output logic                         all_up,
  output logic                         all_down,
  output logic                         busy
);

  localparam int UCW = $clog2(NUM_CH+1);
  localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAG_LAST  = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [NUM_CH-1:0] ALL_ONES   = '1;

  typedef enum logic [2:0] {IDLE, STARTUP, RAMP_UP, UP, RAMP_DOWN} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              warm, warm_n;
  logic [NUM_CH-1:0] en_n, en_up, en_dn;
  logic [UCW-1:0]    pc_n;
  logic              busy_n;

  // Thermometer step up / down by one channel.
  assign en_up = (enable << 1) | NUM_CH'(1);
  assign en_dn = enable >> 1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    warm_n  = warm;
    en_n    = enable;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (run) state_n = warm ? RAMP_UP : STARTUP;
      end
      STARTUP: begin
        if (!run) begin
          // Abort: warm stays clear, so the next request repeats startup.
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == START_LAST) begin
          en_n    = en_up;
          warm_n  = 1'b1;
          cnt_n   = '0;
          state_n = (en_up == ALL_ONES) ? UP : RAMP_UP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RAMP_UP: begin
        if (!run) begin
          if (enable == '0) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            // Preload so the first channel drops on the very next edge.
            state_n = RAMP_DOWN;
            cnt_n   = STAG_LAST;
          end
        end else if (cnt == STAG_LAST) begin
          en_n  = en_up;
          cnt_n = '0;
          if (en_up == ALL_ONES) state_n = UP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      UP: begin
        cnt_n = '0;
        if (!run) begin
          state_n = RAMP_DOWN;
          cnt_n   = STAG_LAST;
        end
      end
      RAMP_DOWN: begin
        if (run) begin
          // Reversal wins over a pending drop; a fully-up vector needs no ramp.
          cnt_n   = '0;
          state_n = (enable == ALL_ONES) ? UP : RAMP_UP;
        end else if (cnt == STAG_LAST) begin
          en_n  = en_dn;
          cnt_n = '0;
          if (en_dn == '0) state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    pc_n = '0;
    for (int i = 0; i < NUM_CH; i++) pc_n = pc_n + UCW'(en_n[i]);
  end

  assign busy_n = (state_n == STARTUP) || (state_n == RAMP_UP) || (state_n == RAMP_DOWN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      warm     <= 1'b0;
      enable   <= '0;
      up_count <= '0;
      all_up   <= 1'b0;
      all_down <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      warm     <= warm_n;
      enable   <= en_n;
      up_count <= pc_n;
      all_up   <= (en_n == ALL_ONES);
      all_down <= (en_n == '0);
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_rx_tx_enable_seq.sv
// Bench for rx_tx_enable_seq: a default instance (4 ch, 16/8) and a minimal
// instance (1 ch, 1/1) share clock and reset. An event-based model tracks
// the enabled level per instance and the absolute edge of the next step.
module tb_rx_tx_enable_seq;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       run = 1'b0;
  logic       run1 = 1'b0;
  logic [3:0] en0;
  logic [2:0] uc0;
  logic       au0, ad0, bz0;
  logic [0:0] en1;
  logic [0:0] uc1;
  logic       au1, ad1, bz1;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  always #5 clk = ~clk;

  rx_tx_enable_seq #(.NUM_CH(4), .STARTUP_CYCLES(16), .STAGGER_CYCLES(8), .CNT_W(16)) dut0 (
    .clk(clk), .resetn(resetn), .run(run), .enable(en0), .up_count(uc0),
    .all_up(au0), .all_down(ad0), .busy(bz0));

  rx_tx_enable_seq #(.NUM_CH(1), .STARTUP_CYCLES(1), .STAGGER_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .resetn(resetn), .run(run1), .enable(en1), .up_count(uc1),
    .all_up(au1), .all_down(ad1), .busy(bz1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  n_ch[2]  = '{4, 1};
  int  t_st[2]  = '{16, 1};
  int  t_sg[2]  = '{8, 1};
  int  lvl[2];
  int  due[2];
  bit  pend[2];
  bit  warm[2];
  bit  prv[2];
  int  cyc = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        lvl[i] = 0; pend[i] = 0; warm[i] = 0; prv[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit r;
        r = (i == 0) ? run : run1;
        if (r != prv[i]) begin
          // Any change of run discards progress toward the next step.
          pend[i] = 0;
          if (r && lvl[i] < n_ch[i]) begin
            pend[i] = 1;
            due[i]  = cyc + (warm[i] ? t_sg[i] : t_st[i]);
          end else if (!r && lvl[i] > 0) begin
            pend[i] = 1;
            due[i]  = cyc + 1;
          end
        end else if (pend[i] && cyc == due[i]) begin
          pend[i] = 0;
          if (r) begin
            lvl[i]++;
            warm[i] = 1;
            if (lvl[i] < n_ch[i]) begin pend[i] = 1; due[i] = cyc + t_sg[i]; end
          end else begin
            lvl[i]--;
            if (lvl[i] > 0) begin pend[i] = 1; due[i] = cyc + t_sg[i]; end
          end
        end
        prv[i] = r;
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] a_en[2], a_uc[2];
  logic        a_au[2], a_ad[2], a_bz[2];
  assign a_en[0] = 32'(en0);  assign a_en[1] = 32'(en1);
  assign a_uc[0] = 32'(uc0);  assign a_uc[1] = 32'(uc1);
  assign a_au[0] = au0;       assign a_au[1] = au1;
  assign a_ad[0] = ad0;       assign a_ad[1] = ad1;
  assign a_bz[0] = bz0;       assign a_bz[1] = bz1;

  logic [31:0] last_en[2];
  bit          rst_seen = 1'b1;
  always @(negedge resetn) rst_seen = 1'b1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e;
      e = (32'd1 << lvl[i]) - 32'd1;
      chk($sformatf("enable[%0d]", i), a_en[i], e);
      chk($sformatf("up_count[%0d]", i), a_uc[i], 32'(lvl[i]));
      chk($sformatf("all_up[%0d]", i), 32'(a_au[i]), 32'(lvl[i] == n_ch[i]));
      chk($sformatf("all_down[%0d]", i), 32'(a_ad[i]), 32'(lvl[i] == 0));
      chk($sformatf("busy[%0d]", i), 32'(a_bz[i]),
          32'(prv[i] ? (lvl[i] < n_ch[i]) : (lvl[i] > 0)));
      chk($sformatf("therm[%0d]", i), a_en[i] & (a_en[i] + 32'd1), 32'd0);
      chk($sformatf("popcnt[%0d]", i), a_uc[i], 32'($countones(a_en[i])));
      if (!rst_seen && resetn)
        chk($sformatf("onestep[%0d]", i), 32'($countones(a_en[i] ^ last_en[i]) <= 1), 32'd1);
      last_en[i] = a_en[i];
    end
    if (resetn) rst_seen = 1'b0;
  end

  // ---------------- directed + random stimulus ----------------
  task automatic adv_to(input int k);
    repeat (k - cur) @(posedge clk);
    cur = k;
    #1;
  endtask

  // Reset, then present run=1 so that the next edge (edge 0) samples it.
  task automatic restart();
    @(posedge clk); #1;
    resetn = 1'b0; run = 1'b0; run1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    cur = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable", 32'(en0), 32'h0);
    chk("rst_all_down", 32'(ad0), 32'h1);
    chk("rst_busy", 32'(bz0), 32'h0);

    // Cold start ramp-up, ramp-down, warm restart, NUM_CH=1 pulses.
    restart();
    adv_to(15);  chk("t1_e15", 32'(en0), 32'h0);
    adv_to(16);  chk("t1_e16", 32'(en0), 32'h1);
    adv_to(23);  chk("t1_e23", 32'(en0), 32'h1);
    adv_to(24);  chk("t1_e24", 32'(en0), 32'h3);
    adv_to(32);  chk("t1_e32", 32'(en0), 32'h7);
    adv_to(40);  chk("t1_e40", 32'(en0), 32'hf);
    chk("t1_allup", 32'(au0), 32'h1);
    chk("t1_busy", 32'(bz0), 32'h0);
    adv_to(99);  run = 1'b0;
    adv_to(100); chk("t2_e100", 32'(en0), 32'hf);
    adv_to(101); chk("t2_e101", 32'(en0), 32'h7);
    adv_to(109); chk("t2_e109", 32'(en0), 32'h3);
    adv_to(117); chk("t2_e117", 32'(en0), 32'h1);
    adv_to(124); chk("t2_e124", 32'(en0), 32'h1);
    adv_to(125); chk("t2_e125", 32'(en0), 32'h0);
    chk("t2_alldown", 32'(ad0), 32'h1);
    adv_to(199); run = 1'b1;
    adv_to(207); chk("t3_e207", 32'(en0), 32'h0);
    adv_to(208); chk("t3_e208", 32'(en0), 32'h1);
    adv_to(232); chk("t3_e232", 32'(en0), 32'hf);
    adv_to(239); run1 = 1'b1;
    adv_to(241); chk("t6_rise", 32'(en1), 32'h1);
    run1 = 1'b0;
    adv_to(242); chk("t6_hold", 32'(en1), 32'h1);
    adv_to(243); chk("t6_fall", 32'(en1), 32'h0);
    adv_to(249); run1 = 1'b1;
    adv_to(250); run1 = 1'b0;
    adv_to(252); chk("t6_pulse", 32'(en1), 32'h0);

    // Mid-ramp reversal.
    restart();
    adv_to(29);  run = 1'b0;
    adv_to(30);  chk("t4_e30", 32'(en0), 32'h3);
    adv_to(31);  chk("t4_e31", 32'(en0), 32'h1);
    adv_to(39);  chk("t4_e39", 32'(en0), 32'h0);
    adv_to(49);  run = 1'b1;
    adv_to(57);  chk("t4_e57", 32'(en0), 32'h0);
    adv_to(58);  chk("t4_e58", 32'(en0), 32'h1);

    // Asynchronous reset mid-ramp.
    restart();
    adv_to(28);  chk("t5_e28", 32'(en0), 32'h3);
    #2; resetn = 1'b0;
    #1;
    chk("t5_async_en", 32'(en0), 32'h0);
    chk("t5_async_uc", 32'(uc0), 32'h0);
    chk("t5_async_ad", 32'(ad0), 32'h1);
    chk("t5_async_au", 32'(au0), 32'h0);
    chk("t5_async_bz", 32'(bz0), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    cur = 0;
    adv_to(15);  chk("t5_e15", 32'(en0), 32'h0);
    adv_to(16);  chk("t5_e16", 32'(en0), 32'h1);

    // Random run toggling with rare resets, checked by the model.
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      resetn = 1'b1;
      if ($urandom_range(0, 11) == 0) run = ~run;
      if ($urandom_range(0, 2) == 0) run1 = ~run1;
      if ($urandom_range(0, 499) == 0) resetn = 1'b0;
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
